// File: rtl/vx_mem_pkg.sv
// Shared widths and request/response records for the memory request queue.
// Widths mirror the VX_MEM_* values of the wider codebase.
package vx_mem_pkg;

    localparam int VX_MEM_ADDR_WIDTH = 32;
    localparam int VX_MEM_DATA_WIDTH = 32;
    localparam int VX_MEM_TAG_WIDTH  = 8;

    typedef struct packed {
        logic                         rw;
        logic [VX_MEM_ADDR_WIDTH-1:0] addr;
        logic [VX_MEM_TAG_WIDTH-1:0]  tag;
        logic [VX_MEM_DATA_WIDTH-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic [VX_MEM_DATA_WIDTH-1:0] data;
        logic [VX_MEM_TAG_WIDTH-1:0]  tag;
    } mem_rsp_t;

endpackage

// File: rtl/vx_mem_fifo.sv
// Registered FIFO with a visible head entry and an occupancy count.
// Pushes are ignored when full, pops are ignored when empty.
module vx_mem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             do_push, do_pop;

    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/vx_mem_req_queue.sv
// In-order memory request queue with read credits bounding outstanding reads
// so that the response FIFO can never be overrun by well-behaved memory.
module vx_mem_req_queue
    import vx_mem_pkg::*;
#(
    parameter int REQ_DEPTH   = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic                            core_req_valid,
    output logic                            core_req_ready,
    input  logic                            core_req_rw,
    input  logic [VX_MEM_ADDR_WIDTH-1:0]    core_req_addr,
    input  logic [VX_MEM_TAG_WIDTH-1:0]     core_req_tag,
    input  logic [VX_MEM_DATA_WIDTH-1:0]    core_req_data,

    output logic                            core_rsp_valid,
    output logic [VX_MEM_DATA_WIDTH-1:0]    core_rsp_data,
    output logic [VX_MEM_TAG_WIDTH-1:0]     core_rsp_tag,
    input  logic                            core_rsp_ready,

    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_rw,
    output logic [VX_MEM_ADDR_WIDTH-1:0]    mem_req_addr,
    output logic [VX_MEM_TAG_WIDTH-1:0]     mem_req_tag,
    output logic [VX_MEM_DATA_WIDTH-1:0]    mem_req_data,

    input  logic                            mem_rsp_valid,
    input  logic [VX_MEM_DATA_WIDTH-1:0]    mem_rsp_data,
    input  logic [VX_MEM_TAG_WIDTH-1:0]     mem_rsp_tag,

    output logic [$clog2(MAX_PENDING):0]    pending_reads,
    output logic                            rsp_overflow
);
    localparam int CW = $clog2(MAX_PENDING);
    localparam logic [CW:0] MAX_CREDITS = (CW+1)'(MAX_PENDING);
    localparam logic [CW:0] CNT_ONE     = (CW+1)'(1);

    mem_req_t req_in, req_head;
    mem_rsp_t rsp_in, rsp_head;
    logic     req_full, req_empty, rsp_full, rsp_empty;
    logic [$clog2(REQ_DEPTH):0] req_count;
    logic [CW:0] rsp_count;
    logic [CW:0] credits_reg, credits_next, pending_reg, pending_next;
    logic        overflow_reg;
    logic        req_push, req_pop, read_issue, rsp_push, rsp_pop, rsp_drop, pend_dec;
    logic        unused_counts;

    assign unused_counts = ^{req_count, rsp_count};

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign core_req_ready = !req_full && !reset;
    assign req_push       = core_req_valid && core_req_ready;
    assign req_in         = '{rw: core_req_rw, addr: core_req_addr,
                              tag: core_req_tag, data: core_req_data};

    vx_mem_fifo #(.WIDTH($bits(mem_req_t)), .DEPTH(REQ_DEPTH)) req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_push),
        .push_data (req_in),
        .pop       (req_pop),
        .head_data (req_head),
        .full      (req_full),
        .empty     (req_empty),
        .count     (req_count)
    );

    // A read at the head stalls everything behind it until a credit is free.
    assign mem_req_valid = !req_empty && (req_head.rw || credits_reg != '0);
    assign mem_req_rw    = req_head.rw;
    assign mem_req_addr  = req_head.addr;
    assign mem_req_tag   = req_head.tag;
    assign mem_req_data  = req_head.data;
    assign req_pop       = mem_req_valid && mem_req_ready;
    assign read_issue    = req_pop && !req_head.rw;

    // Beats that the credit scheme cannot account for are dropped and flagged.
    assign rsp_drop = mem_rsp_valid && (rsp_full || pending_reg == '0);
    assign rsp_push = mem_rsp_valid && !rsp_drop;
    assign pend_dec = mem_rsp_valid && pending_reg != '0;
    assign rsp_in   = '{data: mem_rsp_data, tag: mem_rsp_tag};

    vx_mem_fifo #(.WIDTH($bits(mem_rsp_t)), .DEPTH(MAX_PENDING)) rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_push),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .head_data (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    assign core_rsp_valid = !rsp_empty;
    assign core_rsp_data  = rsp_head.data;
    assign core_rsp_tag   = rsp_head.tag;
    assign rsp_pop        = core_rsp_valid && core_rsp_ready;

    always_comb begin
        credits_next = credits_reg;
        pending_next = pending_reg;
        if (read_issue && !rsp_pop)
            credits_next = credits_reg - CNT_ONE;
        else if (rsp_pop && !read_issue && credits_reg != MAX_CREDITS)
            credits_next = credits_reg + CNT_ONE;
        if (read_issue && !pend_dec)
            pending_next = pending_reg + CNT_ONE;
        else if (pend_dec && !read_issue)
            pending_next = pending_reg - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_reg  <= MAX_CREDITS;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            credits_reg  <= credits_next;
            pending_reg  <= pending_next;
            if (rsp_drop) overflow_reg <= 1'b1;
        end
    end

    assign pending_reads = pending_reg;
    assign rsp_overflow  = overflow_reg;

endmodule

// File: tb/tb_vx_mem_req_queue.sv
// Directed bench for vx_mem_req_queue: a small memory responder answers reads
// three cycles after issue; expected values are written out per scenario.
module tb_vx_mem_req_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req_valid = 1'b0, core_req_ready, core_req_rw = 1'b0;
    logic [31:0] core_req_addr = '0, core_req_data = '0;
    logic [7:0]  core_req_tag = '0;
    logic        core_rsp_valid, core_rsp_ready = 1'b0;
    logic [31:0] core_rsp_data;
    logic [7:0]  core_rsp_tag;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_rw;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [7:0]  mem_req_tag;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic [7:0]  mem_rsp_tag = '0;
    logic [2:0]  pending_reads;
    logic        rsp_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int peak     = 0;
    bit mem_auto = 1'b0;

    logic [7:0]  pend_q[$];
    int          pend_due[$];
    logic [31:0] issue_q[$];
    logic [7:0]  got_tag[$];
    logic [31:0] got_data[$];

    vx_mem_req_queue dut (
        .clk            (clk),
        .reset          (reset),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_rw    (core_req_rw),
        .core_req_addr  (core_req_addr),
        .core_req_tag   (core_req_tag),
        .core_req_data  (core_req_data),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_data  (core_rsp_data),
        .core_rsp_tag   (core_rsp_tag),
        .core_rsp_ready (core_rsp_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_tag    (mem_req_tag),
        .mem_req_data   (mem_req_data),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .pending_reads  (pending_reads),
        .rsp_overflow   (rsp_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic clear_logs();
        issue_q.delete();
        got_tag.delete();
        got_data.delete();
    endtask

    // One clock: drive any due memory response, log handshakes, advance.
    task automatic clk_cycle();
        if (mem_auto) begin
            mem_rsp_valid = 1'b0;
            if (pend_q.size() > 0 && pend_due[0] <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_tag   = pend_q[0];
                mem_rsp_data  = {24'hA5A5A5, pend_q[0]};
                void'(pend_q.pop_front());
                void'(pend_due.pop_front());
            end
        end
        #1;
        if (mem_req_valid === 1'b1 && mem_req_ready) begin
            issue_q.push_back(mem_req_addr);
            $display("[%0d] mem issue rw=%0d addr=0x%0h tag=0x%0h", cyc, mem_req_rw, mem_req_addr, mem_req_tag);
            if (!mem_req_rw && mem_auto) begin
                pend_q.push_back(mem_req_tag);
                pend_due.push_back(cyc + 3);
            end
        end
        if (core_rsp_valid === 1'b1 && core_rsp_ready) begin
            got_tag.push_back(core_rsp_tag);
            got_data.push_back(core_rsp_data);
            $display("[%0d] core rsp tag=0x%0h data=0x%0h", cyc, core_rsp_tag, core_rsp_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (int'(pending_reads) > peak) peak = int'(pending_reads);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) clk_cycle();
    endtask

    task automatic offer(input logic rw, input logic [31:0] addr, input logic [7:0] tag);
        core_req_valid = 1'b1;
        core_req_rw    = rw;
        core_req_addr  = addr;
        core_req_tag   = tag;
        core_req_data  = 32'hC0DE_0000 | {24'h0, tag};
        clk_cycle();
        core_req_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        clk_cycle();
        check("rst_req_ready", core_req_ready, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_rsp_valid", core_rsp_valid, 0);
        check("rst_pending", pending_reads, 0);
        check("rst_overflow", rsp_overflow, 0);
        check("rst_credits", dut.credits_reg, 4);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", core_req_ready, 1);

        // Three reads, responses three cycles after issue
        mem_auto = 1'b1; mem_req_ready = 1'b1; core_rsp_ready = 1'b1;
        clear_logs(); peak = 0;
        core_req_valid = 1'b1; core_req_rw = 1'b0; core_req_addr = 32'h4; core_req_tag = 8'd1;
        #1;
        check("no_bypass", mem_req_valid, 0);
        for (int i = 1; i <= 3; i++) offer(1'b0, 32'(i * 4), 8'(i));
        run(12);
        check("r3_count", got_tag.size(), 3);
        for (int i = 0; i < 3 && i < got_tag.size(); i++) begin
            check("r3_tag", got_tag[i], i + 1);
            check("r3_data", got_data[i], {24'hA5A5A5, 8'(i + 1)});
        end
        check("r3_peak", peak, 3);
        check("r3_credits", dut.credits_reg, 4);
        check("r3_pending", pending_reads, 0);

        // Five reads with core responses stalled: credits cap issue at four
        clear_logs(); core_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) offer(1'b0, 32'h200 + 32'(i * 4), 8'h11 + 8'(i));
        run(10);
        check("cr_issued", issue_q.size(), 4);
        check("cr_blocked", mem_req_valid, 0);
        check("cr_head_tag", mem_req_tag, 8'h15);
        check("cr_credits0", dut.credits_reg, 0);
        check("cr_rsp_valid", core_rsp_valid, 1);
        check("cr_rsp_tag", core_rsp_tag, 8'h11);
        core_rsp_ready = 1'b1;
        clk_cycle();
        core_rsp_ready = 1'b0;
        check("cr_unblock", mem_req_valid, 1);
        clk_cycle();
        check("cr_issued5", issue_q.size(), 5);
        if (issue_q.size() == 5) check("cr_addr5", issue_q[4], 32'h210);
        core_rsp_ready = 1'b1;
        run(12);
        check("cr_count", got_tag.size(), 5);
        for (int i = 0; i < 5 && i < got_tag.size(); i++) check("cr_order", got_tag[i], 8'h11 + 8'(i));
        check("cr_credits", dut.credits_reg, 4);

        // Writes backpressured by memory: four fit, fifth refused
        clear_logs(); mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            core_req_valid = 1'b1; core_req_rw = 1'b1;
            core_req_addr = 32'h100 + 32'(i * 4); core_req_tag = 8'h20 + 8'(i);
            core_req_data = 32'hC0DE_0000 + 32'(i);
            #1;
            check("wr_accept", core_req_ready, (i < 4) ? 1 : 0);
            clk_cycle();
        end
        core_req_valid = 1'b0; mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wr_valid", mem_req_valid, 1);
            check("wr_addr", mem_req_addr, 32'h100 + 32'(i * 4));
            check("wr_data", mem_req_data, 32'hC0DE_0000 + 32'(i));
            clk_cycle();
        end
        check("wr_done", mem_req_valid, 0);
        run(4);
        check("wr_no_rsp", got_tag.size(), 0);
        check("wr_credits", dut.credits_reg, 4);

        // Read blocked on credits also blocks the write behind it
        clear_logs(); core_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) offer(1'b0, 32'h300 + 32'(i * 4), 8'h31 + 8'(i));
        run(10);
        check("mx_credits0", dut.credits_reg, 0);
        issue_q.delete();
        offer(1'b1, 32'h10, 8'h40);
        offer(1'b0, 32'h20, 8'h41);
        offer(1'b1, 32'h30, 8'h42);
        run(5);
        check("mx_issued", issue_q.size(), 1);
        if (issue_q.size() >= 1) check("mx_first", issue_q[0], 32'h10);
        check("mx_blocked", mem_req_valid, 0);
        check("mx_head", mem_req_addr, 32'h20);
        core_rsp_ready = 1'b1;
        clk_cycle();
        core_rsp_ready = 1'b0;
        run(4);
        check("mx_issued3", issue_q.size(), 3);
        if (issue_q.size() == 3) begin
            check("mx_second", issue_q[1], 32'h20);
            check("mx_third", issue_q[2], 32'h30);
        end
        core_rsp_ready = 1'b1;
        run(12);
        check("mx_rsp_count", got_tag.size(), 5);
        if (got_tag.size() == 5) check("mx_last_tag", got_tag[4], 8'h41);
        check("mx_credits", dut.credits_reg, 4);
        check("mx_pending", pending_reads, 0);

        // Unsolicited response
        clear_logs(); mem_auto = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_tag = 8'h77; mem_rsp_data = 32'hDEAD_BEEF;
        clk_cycle();
        mem_rsp_valid = 1'b0;
        check("ovf_set", rsp_overflow, 1);
        check("ovf_no_rsp", core_rsp_valid, 0);
        run(3);
        check("ovf_sticky", rsp_overflow, 1);
        check("ovf_no_rsp2", core_rsp_valid, 0);

        // Reset with queued requests and a buffered response
        clear_logs(); mem_auto = 1'b1; core_rsp_ready = 1'b0; mem_req_ready = 1'b1;
        offer(1'b0, 32'h500, 8'h50);
        run(6);
        check("mr_rsp_buffered", core_rsp_valid, 1);
        mem_req_ready = 1'b0;
        offer(1'b1, 32'h600, 8'h60);
        offer(1'b1, 32'h604, 8'h61);
        check("mr_req_queued", mem_req_valid, 1);
        reset = 1'b1;
        clk_cycle();
        check("mr_req_ready", core_req_ready, 0);
        check("mr_mem_valid", mem_req_valid, 0);
        check("mr_rsp_valid", core_rsp_valid, 0);
        check("mr_pending", pending_reads, 0);
        check("mr_overflow", rsp_overflow, 0);
        check("mr_credits", dut.credits_reg, 4);
        reset = 1'b0;
        pend_q.delete(); pend_due.delete();
        #1;
        check("mr_req_ready_after", core_req_ready, 1);
        clear_logs(); core_rsp_ready = 1'b1; mem_req_ready = 1'b1;
        run(6);
        check("mr_no_stale_rsp", got_tag.size(), 0);
        check("mr_no_stale_req", issue_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
